// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, tick constants and the
// fractional baud tick-threshold rule used by both transmitter and receiver.
package uart_pkg;
    localparam int unsigned UART_TICKS_PER_BIT = 4;
    localparam int unsigned UART_DATA_BITS     = 8;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Long ticks (clk_div+1 cycles) are spread evenly over each group of 8 by
    // comparing the bit-reversed super counter against the fractional part.
    function automatic logic uart_tick_due(input logic [2:0]  supercnt,
                                           input int unsigned cnt,
                                           input int unsigned clk_div,
                                           input int unsigned clk_part);
        logic [2:0] srev;
        srev = {supercnt[0], supercnt[1], supercnt[2]};
        if (32'(srev) < clk_part) begin
            return cnt >= clk_div;
        end
        return cnt >= clk_div - 1;
    endfunction
endpackage

// File: rtl/uart_tx_if.sv
// Byte stream handshake between the user and the UART transmitter.
interface uart_tx_if;
    logic                 tvalid;
    logic                 tready;
    uart_pkg::uart_byte_t tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty are registered flags.
module uart_tx_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + FIFO_AW'(do_push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/uart_tx.sv
// UART 8N1/8N2 transmitter: free-running fractional tick generator, a
// small byte FIFO and a tick-aligned framing state machine.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 108,
    parameter int unsigned CLK_PART  = 4,
    parameter int unsigned FIFO_AW   = 3,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  usr,
    output logic      tx,
    output logic      busy
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam int unsigned QW    = $clog2(UART_TICKS_PER_BIT);

    localparam logic [1:0]    S_IDLE   = 2'(IDLE);
    localparam logic [1:0]    S_START  = 2'(START);
    localparam logic [1:0]    S_DATA   = 2'(DATA);
    localparam logic [1:0]    S_STOP   = 2'(STOP);
    localparam logic [QW-1:0] Q_LAST   = QW'(UART_TICKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       supercnt_q, supercnt_d;
    logic             tick;

    logic [1:0]       state_q, state_d;
    logic [QW-1:0]    q_q, q_d;
    logic [2:0]       bitidx_q, bitidx_d;
    uart_byte_t       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             stop_ext_q, stop_ext_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    uart_byte_t       fifo_dout;

    assign fifo_push = usr.tvalid && !fifo_full && !rst;

    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW),
        .WIDTH   (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (usr.tdata),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // Tick generator keeps running across frames so baud phase never resets.
    always_comb begin
        tick       = uart_tick_due(supercnt_q, 32'(cnt_q), CLK_DIV, CLK_PART);
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        supercnt_d = supercnt_q + 3'(tick);
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        bitidx_d   = bitidx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        stop_ext_d = stop_ext_q;
        fifo_pop   = 1'b0;

        if (tick) begin
            q_d = q_q + QW'(1);
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        tx_d     = 1'b0;
                        q_d      = '0;
                        state_d  = S_START;
                    end
                end
                S_START: begin
                    if (q_q == Q_LAST) begin
                        tx_d     = shreg_q[0];
                        bitidx_d = '0;
                        state_d  = S_DATA;
                    end
                end
                S_DATA: begin
                    if (q_q == Q_LAST) begin
                        if (bitidx_q == BIT_LAST) begin
                            tx_d       = 1'b1;
                            stop_ext_d = 1'b0;
                            state_d    = S_STOP;
                        end else begin
                            shreg_d  = shreg_q >> 1;
                            tx_d     = shreg_q[1];
                            bitidx_d = bitidx_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Second stop bit reuses the quarter counter for another lap.
                    if (q_q == Q_LAST) begin
                        if (STOP_BITS == 2 && !stop_ext_q) begin
                            stop_ext_d = 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_dout;
                            tx_d     = 1'b0;
                            state_d  = S_START;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            supercnt_q <= '0;
            state_q    <= S_IDLE;
            q_q        <= '0;
            bitidx_q   <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            stop_ext_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            supercnt_q <= supercnt_d;
            state_q    <= state_d;
            q_q        <= q_d;
            bitidx_q   <= bitidx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            stop_ext_q <= stop_ext_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign usr.tready = !fifo_full;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle behavioural line model plus an
// independent serial decoder and a few hand-computed timing expectations.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned CLK_PART  = 3;
    localparam int unsigned FIFO_AW   = 2;
    localparam int unsigned STOP_BITS = 2;
    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam int          LIMIT     = 20000;
    localparam real         BIT_CYC   = 4.0 * ($itor(CLK_DIV) + $itor(CLK_PART) / 8.0);

    logic clk;
    logic rst;
    logic tx;
    logic busy;

    uart_tx_if u_if ();

    uart_tx #(
        .CLK_DIV   (CLK_DIV),
        .CLK_PART  (CLK_PART),
        .FIFO_AW   (FIFO_AW),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .usr  (u_if),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Period in cycles of tick number k counted from reset.
    function automatic int tick_period(input int k);
        int m, r;
        m = k & 7;
        r = ((m & 1) << 2) | (m & 2) | ((m >> 2) & 1);
        return (r < int'(CLK_PART)) ? int'(CLK_DIV) + 1 : int'(CLK_DIV);
    endfunction

    // Line model: a queue of pending bytes and a queue of per-tick line levels.
    logic [7:0] mq [$];
    bit         lv [$];
    bit         m_on = 1'b0;
    bit         m_active;
    int         m_k, m_down;
    logic       m_tx, m_busy, m_tready;

    always @(posedge clk) begin
        bit         acc, tk;
        logic [7:0] b;
        if (rst) begin
            mq.delete();
            lv.delete();
            m_active = 1'b0;
            m_k      = 0;
            m_down   = tick_period(0) - 1;
            m_on     = 1'b1;
        end else if (m_on) begin
            acc = u_if.tvalid && (mq.size() < DEPTH);
            tk  = (m_down == 0);
            if (tk) begin
                m_k++;
                m_down = tick_period(m_k) - 1;
                if (m_active) begin
                    void'(lv.pop_front());
                    if (lv.size() == 0) m_active = 1'b0;
                end
                if (!m_active && mq.size() != 0) begin
                    b = mq.pop_front();
                    repeat (4) lv.push_back(1'b0);
                    for (int i = 0; i < 8; i++) repeat (4) lv.push_back(b[i]);
                    repeat (4 * STOP_BITS) lv.push_back(1'b1);
                    m_active = 1'b1;
                end
            end else begin
                m_down--;
            end
            if (acc) mq.push_back(u_if.tdata);
        end
        m_tx     = m_active ? lv[0] : 1'b1;
        m_busy   = m_active || (mq.size() != 0);
        m_tready = (mq.size() < DEPTH);
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("tx", 32'(tx), 32'(m_tx));
            check("busy", 32'(busy), 32'(m_busy));
            check("tready", 32'(u_if.tready), 32'(m_tready));
        end
    end

    // Independent serial decoder sampling near bit centres.
    logic [7:0] rx_got [$];
    logic [7:0] want [$];
    logic [7:0] rx_b;
    bit         rx_on = 1'b0;
    int         rx_t, rx_i;

    always @(negedge clk) begin
        if (rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
                rx_i  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == $rtoi(BIT_CYC * ($itor(rx_i) + 0.5))) begin
                if (rx_i == 0) begin
                    check("rx_start", 32'(tx), 32'd0);
                end else if (rx_i <= 8) begin
                    rx_b[rx_i-1] = tx;
                end else begin
                    check("rx_stop", 32'(tx), 32'd1);
                    rx_got.push_back(rx_b);
                    rx_on = 1'b0;
                end
                rx_i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit saw_full = 1'b0;

    task automatic push(input logic [7:0] b, input bit keep);
        int n;
        n = 0;
        u_if.tvalid = 1'b1;
        u_if.tdata  = b;
        while (!u_if.tready && n < LIMIT) begin
            saw_full = 1'b1;
            step();
            n++;
        end
        step();
        u_if.tvalid = 1'b0;
        u_if.tdata  = 8'($urandom);
        check("push_wait", 32'(n >= LIMIT), 32'd0);
        if (keep) want.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < LIMIT) begin
            step();
            n++;
        end
        check("idle_wait", 32'(n >= LIMIT), 32'd0);
        repeat (30) step();
    endtask

    initial begin
        int n, span, nmin;
        u_if.tvalid = 1'b0;
        u_if.tdata  = 8'h00;
        rst         = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(u_if.tready), 32'd1);
        repeat (10) step();

        // 8'h00: start + 8 zero bits = 36 ticks low = 140 + (17 or 18) cycles.
        push(8'h00, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin step(); n++; end
        span = 0;
        while (tx === 1'b0 && span < 1000) begin step(); span++; end
        check_rng("zero_span", span, 157, 158);
        wait_idle();

        // Burst of eight bytes into a four-deep FIFO; frames run back to back.
        for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
        check("burst_saw_full", 32'(saw_full), 32'd1);
        wait_idle();

        // Reset in the middle of data bit 3 of 8'hF0 with two bytes queued.
        push(8'hF0, 1'b0);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin step(); n++; end
        repeat (78) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tready", 32'(u_if.tready), 32'd1);
        repeat (300) step();
        check("mid_rst_quiet", 32'(busy), 32'd0);
        push(8'hA5, 1'b1);
        wait_idle();

        // Push landing on the same edge the FSM pops the only entry.
        n = 0;
        while (m_down != 1 && n < 50) begin step(); n++; end
        push(8'h3C, 1'b1);
        push(8'hC3, 1'b1);
        check("pp_start_tx", 32'(tx), 32'd0);
        check("pp_busy", 32'(busy), 32'd1);
        wait_idle();

        // Loopback-style bytes, then random traffic with random idle gaps.
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h5A, 1'b1);
        push(8'hA5, 1'b1);
        for (int i = 0; i < 6000; i++) begin
            u_if.tvalid = ($urandom_range(0, 99) < 8);
            u_if.tdata  = 8'($urandom);
            if (u_if.tvalid && u_if.tready) want.push_back(u_if.tdata);
            step();
        end
        u_if.tvalid = 1'b0;
        wait_idle();

        check("rx_count", 32'(rx_got.size()), 32'(want.size()));
        nmin = (rx_got.size() < want.size()) ? rx_got.size() : want.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("rx_byte%0d", i), 32'(rx_got[i]), 32'(want[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
